// File: rtl/vco_adc_pkg.sv
// Shared types and defaults for the VCO quantizer readout blocks.
// Holds the FSM state encoding and the per-window count width derivation.
package vco_adc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2
    } state_e;

    localparam int DECIM_DEF      = 64;
    localparam int SETTLE_CYC_DEF = 8;

    // A window of DECIM cycles holds at most DECIM/2 rising edges; one spare bit keeps DECIM itself representable.
    function automatic int cnt_width(input int decim);
        return $clog2(decim) + 1;
    endfunction

endpackage

// File: rtl/vco_edge_sync.sv
// Brings the asynchronous quantizer bit into the clk domain and flags its rising edges.
// A 2-flop synchronizer feeds a history flop; rise is a single-cycle pulse.
module vco_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain plus history flop, running every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= async_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise = s2_r & ~s3_r;

endmodule

// File: rtl/vco_adc_reader.sv
// Readout for the 1-bit VCO quantizer: owns the VCO enable, counts rising edges per DECIM-cycle
// window and presents sinc2 samples y[k] = c[k] + c[k-1] on a valid/ready port.
module vco_adc_reader
    import vco_adc_pkg::*;
#(
    parameter  int DECIM      = DECIM_DEF,
    parameter  int SETTLE_CYC = SETTLE_CYC_DEF,
    localparam int CNT_W      = cnt_width(DECIM),
    localparam int OUT_W      = CNT_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             quantizer_in,
    output logic             vco_enable_n,
    output logic [OUT_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    input  logic             clear_overrun,
    output logic             busy
);

    localparam int WIN_W = $clog2(DECIM);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    state_e             state_r;
    state_e             state_s;
    logic [SET_W-1:0]   settle_cnt_r;
    logic [WIN_W-1:0]   win_idx_r;
    logic [CNT_W-1:0]   acc_r;
    logic [CNT_W-1:0]   c_prev_r;
    logic               primed_r;
    logic [OUT_W-1:0]   y_r;
    logic               y_stb_r;
    logic [OUT_W-1:0]   sample_data_r;
    logic               sample_valid_r;
    logic               overrun_r;
    logic               vco_enable_n_r;
    logic               busy_r;

    logic               rise_s;
    logic [CNT_W-1:0]   c_s;
    logic [OUT_W-1:0]   y_s;
    logic               win_done_s;

    vco_edge_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (quantizer_in),
        .rise     (rise_s)
    );

    // Next-state logic; stop always wins over start.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && !stop) begin
                    state_s = SETTLE;
                end else begin
                    state_s = IDLE;
                end
            end
            SETTLE: begin
                if (stop) begin
                    state_s = IDLE;
                end else if (settle_cnt_r == SET_W'(SETTLE_CYC - 1)) begin
                    state_s = RUN;
                end else begin
                    state_s = SETTLE;
                end
            end
            RUN: begin
                if (stop) begin
                    state_s = IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Window arithmetic: the edge seen in the last window cycle still belongs to that window.
    always_comb begin
        c_s        = acc_r + CNT_W'(rise_s);
        y_s        = OUT_W'(c_s) + OUT_W'(c_prev_r);
        win_done_s = 1'b0;
        if ((state_r == RUN) && (win_idx_r == WIN_W'(DECIM - 1)) && !stop) begin
            win_done_s = 1'b1;
        end else begin
            win_done_s = 1'b0;
        end
    end

    // State register and the registered enable/busy outputs, which follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            vco_enable_n_r <= 1'b1;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            vco_enable_n_r <= (state_s == IDLE);
            busy_r         <= (state_s != IDLE);
        end
    end

    // Settle counter, window counter, accumulator and sinc2 history.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt_r <= '0;
            win_idx_r    <= '0;
            acc_r        <= '0;
            c_prev_r     <= '0;
            primed_r     <= 1'b0;
            y_r          <= '0;
            y_stb_r      <= 1'b0;
        end else begin
            y_stb_r <= 1'b0;
            if (state_r == SETTLE) begin
                settle_cnt_r <= settle_cnt_r + SET_W'(1);
            end else begin
                settle_cnt_r <= '0;
            end
            if (state_r != RUN) begin
                win_idx_r <= '0;
                acc_r     <= '0;
                primed_r  <= 1'b0;
            end else if (win_done_s) begin
                win_idx_r <= '0;
                acc_r     <= '0;
                c_prev_r  <= c_s;
                primed_r  <= 1'b1;
                if (primed_r) begin
                    y_r     <= y_s;
                    y_stb_r <= 1'b1;
                end
            end else begin
                win_idx_r <= win_idx_r + WIN_W'(1);
                acc_r     <= c_s;
            end
        end
    end

    // Output register and handshake; a sample arriving while one is stuck is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_data_r  <= '0;
            sample_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (y_stb_r) begin
                if (sample_valid_r && !sample_ready) begin
                    overrun_r <= 1'b1;
                end else begin
                    sample_data_r  <= y_r;
                    sample_valid_r <= 1'b1;
                end
            end else if (sample_valid_r && sample_ready) begin
                sample_valid_r <= 1'b0;
            end
            if (clear_overrun && !(y_stb_r && sample_valid_r && !sample_ready)) begin
                overrun_r <= 1'b0;
            end
        end
    end

    assign vco_enable_n = vco_enable_n_r;
    assign sample_data  = sample_data_r;
    assign sample_valid = sample_valid_r;
    assign overrun      = overrun_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vco_adc_reader.sv
// Scoreboard bench for vco_adc_reader at DECIM=64, SETTLE_CYC=8.
// Stimulus pushes expected samples; a negedge monitor pops them on every valid & ready transfer.
module tb_vco_adc_reader;

    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             quantizer_in;
    logic             sample_ready;
    logic             clear_overrun;
    logic             vco_enable_n;
    logic [OUT_W-1:0] sample_data;
    logic             sample_valid;
    logic             overrun;
    logic             busy;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int qmode = 0;
    int qcnt  = 0;
    int mon_exp;

    always #5 clk = ~clk;

    vco_adc_reader dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .quantizer_in  (quantizer_in),
        .vco_enable_n  (vco_enable_n),
        .sample_data   (sample_data),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .busy          (busy)
    );

    // Quantizer model: mode 0 = low, 1/2/3 = toggle every 1/2/4 clocks (32/16/8 rising edges per window).
    initial begin
        quantizer_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            qcnt++;
            case (qmode)
                1:       quantizer_in = ~quantizer_in;
                2:       if (qcnt % 2 == 0) quantizer_in = ~quantizer_in;
                3:       if (qcnt % 4 == 0) quantizer_in = ~quantizer_in;
                default: quantizer_in = 1'b0;
            endcase
        end
    end

    // Monitor: every accepted sample must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && sample_valid && sample_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_sample: got %0d, expected no sample", sample_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (int'(sample_data) != mon_exp) begin
                    n_err++;
                    $display("FAIL sample_data: got %0d, expected %0d", sample_data, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            tick();
            c++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_enable_n"}, vco_enable_n, 1);
        chk({tag, "_valid"}, sample_valid, 0);
        chk({tag, "_data"}, sample_data, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_pattern(input int mode, input int expv);
        qmode = mode;
        repeat (16) tick();
        exp_q.push_back(expv);
        exp_q.push_back(expv);
        pulse_start();
        wait_drain(400);
        pulse_stop();
        repeat (80) tick();
        chk("pattern_idle", busy, 0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        start = 1'b0;
        stop = 1'b0;
        sample_ready = 1'b1;
        clear_overrun = 1'b0;
        qmode = 1;
        repeat (4) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // Fast toggling: 32 edges per window, y = 64; first sample 137 cycles after start.
        repeat (3) exp_q.push_back(64);
        pulse_start();
        chk("enable_fall", vco_enable_n, 0);
        chk("busy_on", busy, 1);
        cyc = 0;
        while (!sample_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("first_latency", cyc, 137);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!sample_valid && cyc < 400);
        chk("interval", cyc, 64);
        // start mid-RUN must not restart the window
        cyc = 0;
        do begin
            start = (cyc == 20);
            tick();
            cyc++;
        end while (!sample_valid && cyc < 400);
        start = 1'b0;
        chk("interval_after_start", cyc, 64);
        chk("busy_run", busy, 1);
        wait_drain(200);
        pulse_stop();
        chk("stop_enable_n", vco_enable_n, 1);
        chk("stop_busy", busy, 0);
        repeat (150) tick();

        run_pattern(0, 0);
        run_pattern(2, 32);
        run_pattern(3, 16);

        // start and stop together from IDLE
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_enable_n", vco_enable_n, 1);
        repeat (10) tick();
        chk("startstop_busy_later", busy, 0);

        // Stalled consumer: first sample held, overrun after the next window, stop keeps it pending.
        qmode = 1;
        repeat (16) tick();
        sample_ready = 1'b0;
        pulse_start();
        cyc = 0;
        while (!sample_valid && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("stall_latency", cyc, 137);
        chk("stall_overrun_early", overrun, 0);
        chk("stall_data_first", sample_data, 64);
        repeat (70) tick();
        chk("stall_overrun_set", overrun, 1);
        chk("stall_data_held", sample_data, 64);
        chk("stall_valid_held", sample_valid, 1);
        pulse_stop();
        chk("pend_enable_n", vco_enable_n, 1);
        chk("pend_busy", busy, 0);
        chk("pend_valid", sample_valid, 1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("overrun_cleared", overrun, 0);
        exp_q.push_back(64);
        sample_ready = 1'b1;
        wait_drain(20);
        tick();
        chk("pend_valid_gone", sample_valid, 0);
        repeat (150) tick();

        // Reset in the middle of a conversion with a sample pending.
        sample_ready = 1'b0;
        pulse_start();
        repeat (150) tick();
        chk("pre_rst_valid", sample_valid, 1);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        sample_ready = 1'b1;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
